// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, single-outstanding imem fetch, IF/ID register with one-entry skid and redirect flush
module if_fetch_stage #(
  parameter int inst_SIZE = 16,
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [inst_SIZE-1:0] NOP_INSTR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [PC_WIDTH-1:0]  redirect_pc,
  output logic                 imem_req,
  output logic [PC_WIDTH-1:0]  imem_addr,
  input  logic                 imem_ack,
  input  logic [inst_SIZE-1:0] imem_rdata,
  output logic                 if_valid,
  output logic [inst_SIZE-1:0] if_instr,
  output logic [PC_WIDTH-1:0]  if_pc_plus1
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2, HOLD = 2'd3;
  logic [1:0] state;
  logic [PC_WIDTH-1:0] pc, req_addr, skid_pc1;
  logic [inst_SIZE-1:0] skid_instr;
  logic [PC_WIDTH-1:0] nxt;
  assign nxt = req_addr + 1'b1;
  assign imem_req = (state == REQ) || (state == DROP);
  assign imem_addr = req_addr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      req_addr <= RESET_PC;
      skid_instr <= '0;
      skid_pc1 <= '0;
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc_plus1 <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc_plus1 <= '0;
      skid_instr <= '0;
      skid_pc1 <= '0;
      pc <= redirect_pc;
      // an unacked request cannot be withdrawn, so wait it out in DROP
      if (imem_req && !imem_ack) state <= DROP;
      else begin
        req_addr <= redirect_pc;
        state <= REQ;
      end
    end else begin
      case (state)
        IDLE: begin
          req_addr <= pc;
          state <= REQ;
        end
        REQ: if (imem_ack) begin
          pc <= nxt;
          if (stall) begin
            skid_instr <= imem_rdata;
            skid_pc1 <= nxt;
            state <= HOLD;
          end else begin
            if_valid <= 1'b1;
            if_instr <= imem_rdata;
            if_pc_plus1 <= nxt;
            req_addr <= nxt;
          end
        end
        HOLD: if (!stall) begin
          if_valid <= 1'b1;
          if_instr <= skid_instr;
          if_pc_plus1 <= skid_pc1;
          req_addr <= pc;
          state <= REQ;
        end
        default: if (imem_ack) begin
          req_addr <= pc;
          state <= REQ;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed fetch scenarios checked against a transaction-level model of the instruction stream
module tb_if_fetch_stage;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic imem_req, imem_ack, if_valid;
  logic [15:0] imem_addr, imem_rdata, if_instr, if_pc_plus1;
  logic req2, valid2;
  logic [15:0] addr2, instr2, pc1_2;
  int total = 0, bad = 0;
  int wait_n = 0, cnt = 0;

  always #5 clk = ~clk;

  // memory: ack after wait_n idle cycles of a held request, data = A000|addr
  assign imem_ack = imem_req && (cnt == wait_n);
  assign imem_rdata = 16'hA000 | imem_addr;
  always @(posedge clk) cnt <= (!rst_n || imem_ack || !imem_req) ? 0 : cnt + 1;

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc_plus1(if_pc_plus1)
  );

  if_fetch_stage #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect_valid(1'b0),
    .redirect_pc(16'h0000), .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(16'hA000 | addr2), .if_valid(valid2),
    .if_instr(instr2), .if_pc_plus1(pc1_2)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // model: the decoder sees the sequential stream from the last fetch target
  bit known = 0, p_v = 0, m_drop = 0;
  logic m_v;
  logic [15:0] m_i, m_p, p_i, p_p, m_next, m_daddr;
  always @(posedge clk) begin
    if (!rst_n) begin
      known = 1; m_v = 0; m_i = 0; m_p = 0; p_v = 0; m_drop = 0; m_next = 16'h0000;
    end else if (known) begin
      if (redirect_valid) begin
        if (imem_req && !imem_ack) begin
          if (!m_drop) m_daddr = m_next;
          m_drop = 1;
        end else m_drop = 0;
        m_v = 0; m_i = 0; m_p = 0; p_v = 0; m_next = redirect_pc;
      end else if (imem_ack && m_drop) m_drop = 0;
      else if (imem_ack) begin
        if (stall) begin
          p_v = 1; p_i = 16'hA000 | m_next; p_p = m_next + 16'd1;
        end else begin
          m_v = 1; m_i = 16'hA000 | m_next; m_p = m_next + 16'd1;
        end
        m_next = m_next + 16'd1;
      end else if (p_v && !stall) begin
        m_v = 1; m_i = p_i; m_p = p_p; p_v = 0;
      end
    end
  end

  always @(negedge clk) if (known) begin
    chk("m_valid", if_valid, m_v);
    chk("m_instr", if_instr, m_i);
    chk("m_pc1", if_pc_plus1, m_p);
    if (imem_req) chk("m_addr", imem_addr, m_drop ? m_daddr : m_next);
    if (p_v) chk("m_noreq_hold", imem_req, 0);
  end

  task automatic do_reset();
    rst_n = 0; stall = 0; redirect_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic wait_addr(input logic [15:0] a, input int lim, input string n);
    int k = 0;
    while (!(imem_req && imem_addr == a) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(n, imem_req && imem_addr == a, 1);
  endtask

  initial begin
    int ch;
    logic [15:0] prev;
    repeat (2) @(negedge clk);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_pc1", if_pc_plus1, 16'h0000);
    chk("rst_req", imem_req, 0);
    rst_n = 1;
    @(negedge clk);
    chk("t1_req", imem_req, 1);
    chk("t1_addr0", imem_addr, 16'h0000);
    chk("t1_v0", if_valid, 0);
    chk("t6_addr_ffff", addr2, 16'hFFFF);
    @(negedge clk);
    chk("t1_v1", if_valid, 1);
    chk("t1_i1", if_instr, 16'hA000);
    chk("t1_p1", if_pc_plus1, 16'h0001);
    chk("t1_addr1", imem_addr, 16'h0001);
    chk("t6_pc1_wrap", pc1_2, 16'h0000);
    chk("t6_instr", instr2, 16'hFFFF);
    chk("t6_addr_wrap", addr2, 16'h0000);
    @(negedge clk);
    chk("t1_i2", if_instr, 16'hA001);
    chk("t1_p2", if_pc_plus1, 16'h0002);
    repeat (3) @(negedge clk);
    wait_n = 2;
    repeat (3) @(negedge clk);
    ch = 0;
    prev = if_pc_plus1;
    repeat (12) begin
      @(negedge clk);
      if (if_pc_plus1 != prev) ch++;
      prev = if_pc_plus1;
    end
    chk("t2_rate", ch, 4);
    wait_n = 0;
    do_reset();
    wait_addr(16'h0005, 50, "t3_reach5");
    chk("t3_ack", imem_ack, 1);
    stall = 1;
    repeat (4) begin
      @(negedge clk);
      chk("t3_hold_instr", if_instr, 16'hA004);
      chk("t3_noreq", imem_req, 0);
    end
    stall = 0;
    @(negedge clk);
    chk("t3_rel_instr", if_instr, 16'hA005);
    chk("t3_rel_pc1", if_pc_plus1, 16'h0006);
    chk("t3_rel_addr", imem_addr, 16'h0006);
    @(negedge clk);
    chk("t3_next_instr", if_instr, 16'hA006);
    wait_n = 3;
    do_reset();
    wait_addr(16'h0007, 100, "t4_reach7");
    chk("t4_pending", imem_ack, 0);
    redirect_valid = 1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect_valid = 0;
    chk("t4_flush_v", if_valid, 0);
    chk("t4_flush_i", if_instr, 16'h0000);
    chk("t4_drop_addr", imem_addr, 16'h0007);
    wait_addr(16'h0040, 20, "t4_reach40");
    for (int k = 0; k < 20 && !if_valid; k++) @(negedge clk);
    chk("t4_instr40", if_instr, 16'hA040);
    chk("t4_pc41", if_pc_plus1, 16'h0041);
    wait_n = 0;
    do_reset();
    wait_addr(16'h0003, 50, "t5_reach3");
    stall = 1; redirect_valid = 1; redirect_pc = 16'h0080;
    @(negedge clk);
    stall = 0; redirect_valid = 0;
    chk("t5_flush_v", if_valid, 0);
    chk("t5_flush_i", if_instr, 16'h0000);
    chk("t5_addr80", imem_addr, 16'h0080);
    @(negedge clk);
    chk("t5_v", if_valid, 1);
    chk("t5_instr80", if_instr, 16'hA080);
    chk("t5_pc81", if_pc_plus1, 16'h0081);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit MIPS core, directly upstream of the instruction field decoder.
- Holds the PC and issues single-outstanding word reads to instruction memory over a req/ack handshake.
- Captures returned instructions into the IF/ID register; its if_instr output feeds the field decoder.
- Supports pipeline stall (one-entry skid buffer) and branch/jump redirect (flush plus discard of in-flight data).

Parameters:
- inst_SIZE, 16, instruction width in bits.
- PC_WIDTH, 16, PC width. Word-addressed, so +1 is the next instruction.
- RESET_PC, 16'h0000, PC value after reset.
- NOP_INSTR, 16'h0000, value driven on if_instr when the IF/ID register is empty or flushed.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hazard unit request: hold the IF/ID register.
- redirect_valid  in  1  branch/jump taken; fetch restarts at redirect_pc.
- redirect_pc  in  PC_WIDTH  redirect target (computed downstream).
- imem_req  out  1  memory request.
- imem_addr  out  PC_WIDTH  request address.
- imem_ack  in  1  read complete; imem_rdata is valid in this cycle.
- imem_rdata  in  inst_SIZE  instruction word.
- if_valid  out  1  IF/ID register holds a valid instruction.
- if_instr  out  inst_SIZE  IF/ID instruction, feeds the field decoder.
- if_pc_plus1  out  PC_WIDTH  address of the fetched instruction + 1.

Behaviour:
- Reset (rst_n low at a clk edge):
  - pc=RESET_PC, req_addr=RESET_PC, state=IDLE.
  - if_valid=0, if_instr=NOP_INSTR, if_pc_plus1=0.
  - Skid buffer empty. imem_req=0.
- Memory interface:
  - imem_req = (state==REQ || state==DROP). imem_addr = req_addr (registered).
  - While imem_req is high, imem_addr is stable until the imem_ack cycle.
  - A request is never withdrawn. Only one request is outstanding at a time.
  - imem_ack is allowed in the same cycle as imem_req (zero-wait memory).
- States IDLE, REQ, DROP, HOLD:
  - IDLE: the next cycle goes to REQ with req_addr<=pc. This state is entered only from reset.
  - REQ, ack and no stall and no redirect:
    - IF/ID <= {1, imem_rdata, req_addr+1}.
    - pc<=req_addr+1, req_addr<=req_addr+1, stay in REQ.
    - Throughput is 1 instruction/cycle with zero-wait memory.
  - REQ, ack and stall and no redirect:
    - skid <= {imem_rdata, req_addr+1}, pc<=req_addr+1, go to HOLD.
    - IF/ID is unchanged.
  - REQ, no ack: stay. IF/ID holds if stall is high; otherwise IF/ID is unchanged.
  - HOLD:
    - No request is issued.
    - When stall is low: IF/ID <= {1, skid}, req_addr<=pc, go to REQ.
  - DROP:
    - The outstanding request completes. Data returned on ack is discarded and IF/ID is not loaded.
    - On ack: req_addr<=pc, go to REQ.
- Redirect (redirect_valid=1) has priority over stall and ack:
  - IF/ID flushed: if_valid<=0, if_instr<=NOP_INSTR, if_pc_plus1<=0.
  - Skid cleared. pc<=redirect_pc.
  - In REQ or DROP without ack: go to DROP.
  - In REQ or DROP with ack: data discarded, req_addr<=redirect_pc, go to REQ.
  - In HOLD or IDLE: req_addr<=redirect_pc, go to REQ.
- Stall without redirect:
  - IF/ID outputs are held unchanged.
  - The stage never drops or duplicates an instruction.
- Arithmetic: PC increments are modulo 2^PC_WIDTH. 0xFFFF+1 = 0x0000.
- Reset mid-transaction: state returns to IDLE and any in-flight ack is ignored. The memory model must also be reset.
- Latency: instruction at address A is visible on if_* one cycle after its ack edge.

Test Plan:
1. Reset, then zero-wait memory (ack=req, rdata=16'hA000|addr) -> imem_addr 0,1,2… on consecutive cycles; if_instr A000, A001, A002… on consecutive cycles; if_pc_plus1 = 1, 2, 3…; first if_valid=1 two cycles after rst_n rises.
2. Memory with 2 wait cycles (ack on 3rd cycle of req) -> imem_addr held 3 cycles each; if_valid updates once per 3 cycles; addresses strictly sequential.
3. stall=1 in the ack cycle of address 5, held 4 cycles -> IF/ID keeps instr@4 throughout; no request while in HOLD; after release, instr@5 loads, then a request for address 6; no loss or duplication.
4. redirect_valid=1, redirect_pc=16'h0040 while a 3-wait-cycle request to address 7 is pending -> if_valid=0 / NOP next cycle; address 7's data discarded; next imem_addr=0x0040; if_instr then shows instr@0x40 with if_pc_plus1=0x41.
5. redirect_valid, stall and ack all in the same cycle -> flush wins; skid empty; next request to redirect_pc; stall does not preserve the old IF/ID value.
6. RESET_PC=16'hFFFF with zero-wait memory -> first if_pc_plus1=0x0000; next imem_addr=0x0000.
